decoder_round_driver: RTL and testbench

DECODER_ROUND_DRIVER -- requirements
Module: decoder_round_driver

---
 rtl/decoder_round_driver_pkg.sv | 31 +++
 rtl/decoder_round_driver_if.sv | 24 ++
 rtl/decoder_round_driver_syndrome_byte_packer.sv | 31 +++
 rtl/decoder_round_driver.sv | 164 ++++++++++++++++
 tb/tb_decoder_round_driver.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decoder_round_driver_pkg.sv
// Shared constants for the decoder round driver: FSM state encodings,
// stream widths, result header field positions and small elaboration helpers.
package decoder_round_driver_pkg;

  // Round FSM state encodings (kept as plain constants for legacy tools).
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_HDR0  = 3'd4;
  localparam logic [2:0] ST_HDR1  = 3'd5;
  localparam logic [2:0] ST_ROOTS = 3'd6;

  // Stream widths.
  localparam int IN_W  = 8;
  localparam int OUT_W = 32;

  // Second header word layout: timeout flag on top, iteration count at the bottom.
  localparam int HDR_TIMEOUT_BIT = 31;
  localparam int HDR_ITER_LSB    = 0;
  localparam int HDR_ITER_W      = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/decoder_round_driver_if.sv
// Byte-in / word-out stream bundle of the decoder round driver.
// master = the environment side, slave = the driver itself.
interface decoder_round_driver_if;
  import decoder_round_driver_pkg::*;

  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

endinterface

// File: rtl/decoder_round_driver_syndrome_byte_packer.sv
// Assembles the syndrome byte stream into the flat measurement vector.
// Byte k lands on bits [8k+7:8k]; bits of the last byte that fall at or
// above PU_COUNT have no destination and are dropped.
module syndrome_byte_packer
  import decoder_round_driver_pkg::*;
#(
  parameter int PU_COUNT = 18,
  parameter int IDX_W    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                byte_we,
  input  logic [IDX_W-1:0]    byte_idx,
  input  logic [IN_W-1:0]     byte_data,
  output logic [PU_COUNT-1:0] measurements
);

  // Steer each accepted byte into its lane; untouched lanes keep their value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      measurements <= '0;
    end else if (byte_we) begin
      for (int b = 0; b < PU_COUNT; b++) begin
        if (int'(byte_idx) == (b / IN_W)) begin
          measurements[b] <= byte_data[b % IN_W];
        end
      end
    end
  end

endmodule

// File: rtl/decoder_round_driver.sv
// Decoder round driver: collects a syndrome over a byte stream, launches one
// decoder round, captures the decoder result and streams it out as
// cycle-count header, iteration/flag header and one word per root.
// Optional feature macro: DRIVER_TIMEOUT_EN (round watchdog on WAIT).
module decoder_round_driver
  import decoder_round_driver_pkg::*;
#(
  parameter int CODE_DISTANCE_X = 3,
  parameter int CODE_DISTANCE_Z = 2,
  parameter int TIMEOUT_CYCLES  = 4096,
  localparam int MEASUREMENT_ROUNDS = max_int(CODE_DISTANCE_X, CODE_DISTANCE_Z),
  localparam int PU_COUNT      = CODE_DISTANCE_X * CODE_DISTANCE_Z * MEASUREMENT_ROUNDS,
  localparam int ADDRESS_WIDTH = 3 * $clog2(MEASUREMENT_ROUNDS),
  localparam int NUM_IN_WORDS  = ceil_div(PU_COUNT, IN_W)
) (
  input  logic                              clk,
  input  logic                              reset,
  decoder_round_driver_if.slave             bus,
  output logic                              new_round_start,
  output logic [PU_COUNT-1:0]               measurements,
  input  logic                              result_valid,
  input  logic [ADDRESS_WIDTH*PU_COUNT-1:0] roots,
  input  logic [7:0]                        iteration_counter,
  input  logic [31:0]                       cycle_counter
);

  localparam int IDX_W  = (NUM_IN_WORDS > 1) ? $clog2(NUM_IN_WORDS) : 1;
  localparam int BEAT_W = (PU_COUNT > 1) ? $clog2(PU_COUNT) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_IN_WORDS - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PU_COUNT - 1);

  logic [2:0]                        state;
  logic [2:0]                        state_nxt;
  logic [IDX_W-1:0]                  word_idx;
  logic [BEAT_W-1:0]                 beat_idx;
  logic [ADDRESS_WIDTH*PU_COUNT-1:0] roots_q;
  logic [7:0]                        iter_q;
  logic [31:0]                       cyc_q;
  logic                              in_ready_q;
  logic                              byte_acc;
  logic                              capture;
  logic                              wd_fire;
  logic                              timeout_flag;
  logic [ADDRESS_WIDTH-1:0]          cur_root;
  logic [OUT_W-1:0]                  hdr1_word;

  assign byte_acc        = bus.in_valid & in_ready_q;
  assign bus.in_ready    = in_ready_q;
  assign new_round_start = (state == ST_START);
  // A round result is taken either from the decoder or from the watchdog.
  assign capture         = (state == ST_WAIT) & (result_valid | wd_fire);

`ifdef DRIVER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  assign wd_fire      = (state == ST_WAIT) & ~result_valid & (wd_cnt == WD_LAST);
  assign timeout_flag = timeout_q;

  // Watchdog: count WAIT cycles and remember whether the round ended by timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt <= (state == ST_WAIT) ? wd_cnt + 1'b1 : '0;
      if (capture) begin
        timeout_q <= wd_fire;
      end
    end
  end
`else
  assign wd_fire      = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // Next-state selection for the round sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (byte_acc) state_nxt = (NUM_IN_WORDS == 1) ? ST_START : ST_LOAD;
      ST_LOAD:  if (byte_acc && (word_idx == LAST_IDX)) state_nxt = ST_START;
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT:  if (result_valid || wd_fire) state_nxt = ST_HDR0;
      ST_HDR0:  if (bus.out_ready) state_nxt = ST_HDR1;
      ST_HDR1:  if (bus.out_ready) state_nxt = ST_ROOTS;
      ST_ROOTS: if (bus.out_ready && (beat_idx == LAST_BEAT)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Round control: state, byte/beat counters, in_ready and result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      in_ready_q <= 1'b0;
      word_idx   <= '0;
      beat_idx   <= '0;
      roots_q    <= '0;
      iter_q     <= '0;
      cyc_q      <= '0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt == ST_IDLE) || (state_nxt == ST_LOAD);
      if (byte_acc) begin
        word_idx <= (state_nxt == ST_START) ? '0 : word_idx + 1'b1;
      end
      // A timed-out round reports all-zero result fields.
      if (capture) begin
        roots_q <= result_valid ? roots : '0;
        iter_q  <= result_valid ? iteration_counter : '0;
        cyc_q   <= result_valid ? cycle_counter : '0;
      end
      if ((state == ST_ROOTS) && bus.out_ready) begin
        beat_idx <= (beat_idx == LAST_BEAT) ? '0 : beat_idx + 1'b1;
      end
    end
  end

  // Output word selection; pure function of state so it holds under backpressure.
  always_comb begin
    cur_root  = roots_q[beat_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    hdr1_word = '0;
    hdr1_word[HDR_TIMEOUT_BIT] = timeout_flag;
    hdr1_word[HDR_ITER_LSB +: HDR_ITER_W] = iter_q;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_data  = '0;
    case (state)
      ST_HDR0: begin
        bus.out_valid = 1'b1;
        bus.out_data  = cyc_q;
      end
      ST_HDR1: begin
        bus.out_valid = 1'b1;
        bus.out_data  = hdr1_word;
      end
      ST_ROOTS: begin
        bus.out_valid = 1'b1;
        bus.out_data  = OUT_W'(cur_root);
        bus.out_last  = (beat_idx == LAST_BEAT);
      end
      default: begin
        bus.out_valid = 1'b0;
      end
    endcase
  end

  syndrome_byte_packer #(
    .PU_COUNT (PU_COUNT),
    .IDX_W    (IDX_W)
  ) u_packer (
    .clk          (clk),
    .reset        (reset),
    .byte_we      (byte_acc),
    .byte_idx     (word_idx),
    .byte_data    (bus.in_data),
    .measurements (measurements)
  );

endmodule

// File: tb/tb_decoder_round_driver.sv
// Bench for decoder_round_driver (X=3, Z=2): a phase-level reference model
// checked every cycle, plus literal pins for the documented example rounds.
module tb_decoder_round_driver;

  localparam int X   = 3;
  localparam int Z   = 2;
  localparam int TMO = 16;
  localparam int MR  = (X > Z) ? X : Z;
  localparam int PU  = X * Z * MR;
  localparam int AW  = 3 * $clog2(MR);
  localparam int NW  = (PU + 7) / 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             new_round_start;
  logic [PU-1:0]    measurements;
  logic             result_valid;
  logic [AW*PU-1:0] roots;
  logic [7:0]       iteration_counter;
  logic [31:0]      cycle_counter;

  decoder_round_driver_if bus();

  decoder_round_driver #(
    .CODE_DISTANCE_X (X),
    .CODE_DISTANCE_Z (Z),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus),
    .new_round_start   (new_round_start),
    .measurements      (measurements),
    .result_valid      (result_valid),
    .roots             (roots),
    .iteration_counter (iteration_counter),
    .cycle_counter     (cycle_counter)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  typedef enum int {P_ACCEPT, P_START, P_WAIT, P_OUT} phase_t;
  typedef struct packed { logic [31:0] d; logic l; } beat_t;

  phase_t      ph = P_ACCEPT;
  logic        rdy_exp = 1'b0;
  logic [7:0]  byte_q[$];
  logic [PU-1:0] exp_meas = '0;
  beat_t       exp_q[$];
  int          wcnt = 0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_d = '0;
  logic        hold_l = 1'b0;
  logic [31:0] log_d[$];
  logic        log_l[$];
  logic [PU-1:0] meas_at_start = '0;
  int          starts_seen = 0;

  function automatic logic [PU-1:0] pack_bytes();
    logic [8*NW-1:0] w = '0;
    for (int k = 0; k < NW; k++) w = w | ((8*NW)'(byte_q[k]) << (8*k));
    return w[PU-1:0];
  endfunction

  function automatic void push_round(input logic [31:0] cyc, input logic [7:0] it,
                                     input logic [AW*PU-1:0] r, input logic tf);
    beat_t b;
    b.d = cyc; b.l = 1'b0; exp_q.push_back(b);
    b.d = {tf, 23'b0, it}; b.l = 1'b0; exp_q.push_back(b);
    for (int i = 0; i < PU; i++) begin
      b.d = 32'(r >> (i*AW)) & ((32'd1 << AW) - 32'd1);
      b.l = (i == PU-1);
      exp_q.push_back(b);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_new_round_start", new_round_start, 0);
      chk("rst_measurements", measurements, 0);
      ph = P_ACCEPT; byte_q.delete(); exp_q.delete();
      rdy_exp = 1'b0; hold_v = 1'b0; exp_meas = '0;
    end else begin
      chk("in_ready", bus.in_ready, rdy_exp);
      chk("new_round_start", new_round_start, ph == P_START);
      chk("out_valid", bus.out_valid, ph == P_OUT);
      if (ph != P_ACCEPT) chk("measurements", measurements, exp_meas);
      if (ph == P_START) begin
        meas_at_start = measurements;
        starts_seen++;
      end
      if (hold_v) begin
        chk("hold_data", bus.out_data, hold_d);
        chk("hold_last", bus.out_last, hold_l);
      end
      if (ph == P_OUT) begin
        if (exp_q.size() == 0) fail_now("beat_unexpected");
        else begin
          chk("out_data", bus.out_data, exp_q[0].d);
          chk("out_last", bus.out_last, exp_q[0].l);
        end
      end else begin
        chk("out_last_idle", bus.out_last, 0);
      end
      hold_v = bus.out_valid && !bus.out_ready;
      hold_d = bus.out_data;
      hold_l = bus.out_last;
      case (ph)
        P_ACCEPT: if (bus.in_valid && rdy_exp) begin
          byte_q.push_back(bus.in_data);
          if (byte_q.size() == NW) begin
            exp_meas = pack_bytes();
            byte_q.delete();
            ph = P_START;
          end
        end
        P_START: begin
          ph = P_WAIT;
          wcnt = 0;
        end
        P_WAIT: begin
          if (result_valid) begin
            push_round(cycle_counter, iteration_counter, roots, 1'b0);
            ph = P_OUT;
          end
`ifdef DRIVER_TIMEOUT_EN
          else begin
            wcnt++;
            if (wcnt == TMO) begin
              push_round('0, '0, '0, 1'b1);
              ph = P_OUT;
            end
          end
`endif
        end
        P_OUT: if (bus.out_ready) begin
          log_d.push_back(bus.out_data);
          log_l.push_back(bus.out_last);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          if (exp_q.size() == 0) ph = P_ACCEPT;
        end
        default: ph = P_ACCEPT;
      endcase
      rdy_exp = (ph == P_ACCEPT);
    end
  end

  // ---------------- stimulus ----------------
  logic rnd_rdy = 1'b0;
  logic noise   = 1'b0;
  logic gaps    = 1'b0;

  function automatic logic [AW*PU-1:0] rand_roots();
    logic [127:0] t = {$urandom, $urandom, $urandom, $urandom};
    return t[AW*PU-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    if (noise) begin
      result_valid      = ($urandom_range(0, 5) == 0);
      cycle_counter     = $urandom;
      iteration_counter = 8'($urandom);
      roots             = rand_roots();
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if (gaps) repeat ($urandom_range(0, 2)) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) fail_now("byte_accept");
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic wait_phase(input phase_t p, input int lim, input string name);
    int n = 0;
    while (ph != p && n < lim) begin
      tick();
      n++;
    end
    if (n >= lim) fail_now(name);
  endtask

  task automatic pulse_result(input logic [31:0] cyc, input logic [7:0] it, input logic [AW*PU-1:0] r);
    cycle_counter = cyc;
    iteration_counter = it;
    roots = r;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
  endtask

  logic [AW*PU-1:0] dir_roots;
  int               s0;

  initial begin
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    result_valid = 1'b0; roots = '0; iteration_counter = '0; cycle_counter = '0;
    for (int i = 0; i < PU; i++) dir_roots[i*AW +: AW] = AW'(i);
    dir_roots[0 +: AW] = 6'h2A;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // Documented example round: bytes 05 A0 FF, result 0x1234 / 7 / root0=2A.
    log_d.delete(); log_l.delete();
    s0 = starts_seen;
    bus.out_ready = 1'b1;
    send_byte(8'h05); send_byte(8'hA0); send_byte(8'hFF);
    wait_phase(P_WAIT, 20, "wait_phase1");
    chk("ex_meas", meas_at_start, 18'h3A005);
    chk("ex_start_pulses", starts_seen - s0, 1);
    repeat (3) tick();
    pulse_result(32'h1234, 8'd7, dir_roots);
    wait_phase(P_ACCEPT, 200, "done1");
    chk("ex_beats", log_d.size(), 20);
    if (log_d.size() == 20) begin
      chk("ex_beat0", log_d[0], 32'h00001234);
      chk("ex_beat1", log_d[1], 32'h00000007);
      chk("ex_beat2", log_d[2], 32'h0000002A);
      chk("ex_beat3", log_d[3], 32'h00000001);
      chk("ex_last19", log_l[19], 1);
      chk("ex_last18", log_l[18], 0);
    end

    // Backpressure on HDR1 for five cycles.
    log_d.delete(); log_l.delete();
    bus.out_ready = 1'b0;
    send_byte(8'h3C); send_byte(8'h5A); send_byte(8'h01);
    wait_phase(P_WAIT, 20, "wait_phase2");
    pulse_result(32'hCAFE0001, 8'd7, rand_roots());
    begin
      int n = 0;
      while (!bus.out_valid && n < 50) begin tick(); n++; end
      if (n >= 50) fail_now("hdr0_valid");
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hdr1_hold", bus.out_data, 32'h00000007);
      tick();
    end
    bus.out_ready = 1'b1;
    wait_phase(P_ACCEPT, 200, "done2");
    chk("bp_beats", log_d.size(), 20);
    if (log_d.size() == 20) chk("bp_beat1", log_d[1], 32'h00000007);

    // Reset after two of three bytes, then a fresh round.
    send_byte(8'hC3); send_byte(8'h3C);
    reset = 1'b0;
    #1 chk("mid_rst_meas", measurements, 0);
    tick(); tick();
    reset = 1'b1;
    tick();
    log_d.delete(); log_l.delete();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    wait_phase(P_WAIT, 20, "wait_phase3");
    chk("fresh_meas", meas_at_start, 18'h32211);
    pulse_result(32'h0BAD, 8'h42, rand_roots());
    wait_phase(P_ACCEPT, 200, "done3");
    chk("fresh_beats", log_d.size(), 20);

    // Randomised rounds with result noise, backpressure and byte gaps.
    rnd_rdy = 1'b1; noise = 1'b1; gaps = 1'b1;
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < NW; k++) send_byte(8'($urandom));
      wait_phase(P_ACCEPT, 2000, "rnd_done");
    end

`ifdef DRIVER_TIMEOUT_EN
    // Watchdog round: no decoder result at all.
    noise = 1'b0; result_valid = 1'b0;
    log_d.delete(); log_l.delete();
    for (int k = 0; k < NW; k++) send_byte(8'($urandom));
    wait_phase(P_ACCEPT, 500, "tmo_done");
    chk("tmo_beats", log_d.size(), 20);
    if (log_d.size() == 20) begin
      logic [31:0] acc = '0;
      chk("tmo_hdr0", log_d[0], 32'h0);
      chk("tmo_hdr1", log_d[1], 32'h80000000);
      for (int i = 2; i < 20; i++) acc = acc | log_d[i];
      chk("tmo_roots_zero", acc, 32'h0);
    end
`endif

    rnd_rdy = 1'b0; noise = 1'b0;
    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL global_time_limit: run did not finish");
    $fatal(1, "time limit");
  end

endmodule
